// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator. Each channel plays one note with
// a programmable half-period (cycles) and duration (prescaler ticks). A new
// half-period requested mid-note is applied only at a toggle, so the wave never
// produces a runt pulse. All tone bits are OR-mixed onto a registered pin.
//
// Handshake: load is a one-cycle command strobe per channel with no ready
// signal. It is sampled on every rising clock edge. half_period and duration
// are taken on the same edge. A command with a zero half-period or zero
// duration means "stop" while playing and "ignore" while idle.
module tone_gen_multi #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 17,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 100000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*CNT_W-1:0] half_period,
  input  logic [CHANNELS*DUR_W-1:0] duration,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       tone,
  output logic                      mix_out
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {S_IDLE, S_PLAY} state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          mix_q;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Shared prescaler next value: wraps after TICK_DIV-1.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Shared prescaler register, free-running from reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0]  hp_act_q, hp_act_d;
    logic [CNT_W-1:0]  hp_pend_q, hp_pend_d;
    logic [DUR_W-1:0]  dur_rem_q, dur_rem_d;
    logic              tone_q, tone_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  hp_in;
    logic [DUR_W-1:0]  dur_in;
    logic              cmd_ok;
    logic              wrap;

    assign hp_in  = half_period[i*CNT_W +: CNT_W];
    assign dur_in = duration[i*DUR_W +: DUR_W];
    assign cmd_ok = (hp_in != '0) && (dur_in != '0);
    assign wrap   = (ph_cnt_q == hp_act_q - CNT_W'(1));

    // Channel next-state: command handling, phase counting and note expiry.
    // A valid load beats a coinciding expiry; a load landing on a toggle
    // takes effect at that very toggle.
    always_comb begin
      state_d   = state_q;
      ph_cnt_d  = ph_cnt_q;
      hp_act_d  = hp_act_q;
      hp_pend_d = hp_pend_q;
      dur_rem_d = dur_rem_q;
      tone_d    = tone_q;
      done_d    = 1'b0;
      case (state_q)
        S_IDLE: begin
          tone_d = 1'b0;
          if (load[i] && cmd_ok) begin
            state_d   = S_PLAY;
            hp_act_d  = hp_in;
            hp_pend_d = hp_in;
            dur_rem_d = dur_in;
            ph_cnt_d  = '0;
          end
        end
        S_PLAY: begin
          if (load[i] && !cmd_ok) begin
            state_d  = S_IDLE;
            tone_d   = 1'b0;
            ph_cnt_d = '0;
          end else begin
            if (wrap) begin
              ph_cnt_d = '0;
              tone_d   = ~tone_q;
              hp_act_d = load[i] ? hp_in : hp_pend_q;
            end else begin
              ph_cnt_d = ph_cnt_q + CNT_W'(1);
            end
            if (load[i]) begin
              hp_pend_d = hp_in;
              dur_rem_d = dur_in;
            end else if (tick) begin
              if (dur_rem_q == DUR_W'(1)) begin
                state_d  = S_IDLE;
                tone_d   = 1'b0;
                done_d   = 1'b1;
                ph_cnt_d = '0;
              end else begin
                dur_rem_d = dur_rem_q - DUR_W'(1);
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Channel state registers.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q   <= S_IDLE;
        ph_cnt_q  <= '0;
        hp_act_q  <= '0;
        hp_pend_q <= '0;
        dur_rem_q <= '0;
        tone_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        ph_cnt_q  <= ph_cnt_d;
        hp_act_q  <= hp_act_d;
        hp_pend_q <= hp_pend_d;
        dur_rem_q <= dur_rem_d;
        tone_q    <= tone_d;
        done_q    <= done_d;
      end
    end

    assign busy[i] = (state_q == S_PLAY);
    assign done[i] = done_q;
    assign tone[i] = tone_q;
  end

  // Registered OR-mix of all channel tones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mix_q <= 1'b0;
    else     mix_q <= |tone;
  end

  assign mix_out = mix_q;

endmodule
